// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, microcode field positions and access-size type for the memory AGU stage
package mem_pkg;
    localparam int MEM_ADDR_BITS = 11;
    localparam logic [24:0] MC_NOP = 25'h0;
    localparam int MEM_TOP_WORD = (1 << (MEM_ADDR_BITS - 2)) - 1;
    localparam int MC_BYTE1_BIT = 0;
    localparam int MC_UPPER_HALF_BIT = 1;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} access_size_t;
endpackage

// File: rtl/mem_span_check.sv
// mem_span_check: flags accesses outside the data aperture or whose span wraps past the top word
module mem_span_check import mem_pkg::*; #(
    parameter int MEM_ADDR_BITS = mem_pkg::MEM_ADDR_BITS
) (
    input  logic [31:0]  ea,
    input  access_size_t size,
    input  logic         en,
    output logic         fault
);
    logic [2:0] span_end;
    // last byte offset within the word plus one; above 4 means the access spills into the next word
    always_comb begin
        span_end = {1'b0, ea[1:0]} + (size == SZ_WORD ? 3'd4 : size == SZ_HALF ? 3'd2 : 3'd1);
        fault    = en && (|ea[31:MEM_ADDR_BITS] || (&ea[MEM_ADDR_BITS-1:2] && span_end > 3'd4));
    end
endmodule

// File: rtl/microcode_s2_decoder.sv
// microcode_s2_decoder: extracts the byte-lane enables from the microcode size field
module microcode_s2_decoder (
    input  logic [1:0] size_field,
    output logic       enable_upper_half,
    output logic       enable_byte_1
);
    assign enable_upper_half = size_field[1];
    assign enable_byte_1     = size_field[0];
endmodule

// File: rtl/mem_agu_stage.sv
// mem_agu_stage: stage-1/stage-2 register with address generation and aperture fault kill; optional AGU_FAULT_COUNT_EN adds fault_count
module mem_agu_stage import mem_pkg::*; #(
    parameter int MEM_ADDR_BITS = mem_pkg::MEM_ADDR_BITS,
    parameter int MC_WIDTH      = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_enable,
    input  logic                valid_in,
    input  logic                flush,
    input  logic [31:0]         base,
    input  logic [31:0]         imm,
    input  logic [31:0]         store_data,
    input  logic [MC_WIDTH-1:0] microcode_s1,
    input  logic                mem_access_s1,
    input  logic                fault_clear,
    output logic [31:0]         addr,
    output logic [31:0]         offset_addr,
    output logic [31:0]         data_in,
    output logic [MC_WIDTH-1:0] microcode_s2,
    output logic                valid_s2,
    output logic                fault_pulse,
    output logic                fault_sticky,
    output logic [31:0]         fault_addr
`ifdef AGU_FAULT_COUNT_EN
    ,output logic [7:0]         fault_count
`endif
);
    logic [31:0]  ea;
    logic         enable_upper_half, enable_byte_1, check_en, fault;
    access_size_t size;

    microcode_s2_decoder u_dec (
        .size_field        (microcode_s1[MC_UPPER_HALF_BIT:MC_BYTE1_BIT]),
        .enable_upper_half (enable_upper_half),
        .enable_byte_1     (enable_byte_1)
    );

    // effective address, access size and which ops are subject to the aperture check
    always_comb begin
        ea       = base + imm;
        size     = enable_upper_half ? SZ_WORD : enable_byte_1 ? SZ_HALF : SZ_BYTE;
        check_en = valid_in & mem_access_s1 & ~flush;
    end

    mem_span_check #(.MEM_ADDR_BITS(MEM_ADDR_BITS)) u_span (
        .ea    (ea),
        .size  (size),
        .en    (check_en),
        .fault (fault)
    );

    // stage register plus sticky fault status; a faulting op stays valid but carries a NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr         <= '0;
            offset_addr  <= '0;
            data_in      <= '0;
            microcode_s2 <= MC_WIDTH'(MC_NOP);
            valid_s2     <= 1'b0;
            fault_pulse  <= 1'b0;
            fault_sticky <= 1'b0;
            fault_addr   <= '0;
        end else if (clk_enable) begin
            addr         <= ea;
            offset_addr  <= ea + 32'd4;
            data_in      <= store_data;
            microcode_s2 <= (flush || fault || !valid_in) ? MC_WIDTH'(MC_NOP) : microcode_s1;
            valid_s2     <= valid_in & ~flush;
            fault_pulse  <= fault;
            fault_sticky <= fault | (fault_sticky & ~fault_clear);
            if (fault && (!fault_sticky || fault_clear))
                fault_addr <= ea;
        end
    end

`ifdef AGU_FAULT_COUNT_EN
    // saturating fault counter; a clear restarts counting from the concurrent fault, if any
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_count <= '0;
        else if (clk_enable)
            fault_count <= fault_clear ? {7'd0, fault} : (fault && fault_count != 8'hFF) ? fault_count + 8'd1 : fault_count;
    end
`endif
endmodule

// File: tb/tb_mem_agu_stage.sv
// tb_mem_agu_stage: directed and randomized checks of mem_agu_stage against a byte-span reference model
module tb_mem_agu_stage;
    import mem_pkg::*;

    logic        clk = 0, rst_n = 0, clk_enable = 0, valid_in = 0, flush = 0, mem_access_s1 = 0, fault_clear = 0;
    logic [31:0] base = 0, imm = 0, store_data = 0;
    logic [24:0] microcode_s1 = 0;
    logic [31:0] addr, offset_addr, data_in, fault_addr;
    logic [24:0] microcode_s2;
    logic        valid_s2, fault_pulse, fault_sticky;
`ifdef AGU_FAULT_COUNT_EN
    logic [7:0]  fault_count;
`endif

    mem_agu_stage dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .valid_in(valid_in), .flush(flush),
        .base(base), .imm(imm), .store_data(store_data), .microcode_s1(microcode_s1),
        .mem_access_s1(mem_access_s1), .fault_clear(fault_clear),
        .addr(addr), .offset_addr(offset_addr), .data_in(data_in), .microcode_s2(microcode_s2),
        .valid_s2(valid_s2), .fault_pulse(fault_pulse), .fault_sticky(fault_sticky), .fault_addr(fault_addr)
`ifdef AGU_FAULT_COUNT_EN
        ,.fault_count(fault_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] e_addr, e_off, e_data, e_faddr;
    logic [24:0] e_mc;
    logic        e_valid, e_pulse, e_sticky;
    int          e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        e_addr = 0; e_off = 0; e_data = 0; e_faddr = 0; e_mc = 0;
        e_valid = 0; e_pulse = 0; e_sticky = 0; e_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, addr, e_addr);
        chk({tag, ".offset_addr"}, offset_addr, e_off);
        chk({tag, ".data_in"}, data_in, e_data);
        chk({tag, ".microcode_s2"}, 32'(microcode_s2), 32'(e_mc));
        chk({tag, ".valid_s2"}, 32'(valid_s2), 32'(e_valid));
        chk({tag, ".fault_pulse"}, 32'(fault_pulse), 32'(e_pulse));
        chk({tag, ".fault_sticky"}, 32'(fault_sticky), 32'(e_sticky));
        chk({tag, ".fault_addr"}, fault_addr, e_faddr);
`ifdef AGU_FAULT_COUNT_EN
        chk({tag, ".fault_count"}, 32'(fault_count), 32'(e_cnt));
`endif
    endtask

    // one clock: drive inputs, advance the reference model on the edge, compare 1 time unit later
    task automatic step(input string tag, input logic ce, input logic v, input logic fl, input logic mem,
                        input logic clr, input logic [31:0] b, input logic [31:0] i, input int sz);
        logic [24:0] m;
        logic [31:0] ea, sd;
        logic        flt;
        m = 25'($urandom);
        m[MC_UPPER_HALF_BIT] = (sz == 4);
        m[MC_BYTE1_BIT] = (sz == 2);
        sd = $urandom;
        clk_enable = ce; valid_in = v; flush = fl; mem_access_s1 = mem; fault_clear = clr;
        base = b; imm = i; store_data = sd; microcode_s1 = m;
        @(posedge clk);
        if (ce) begin
            ea = b + i;
            flt = v && mem && !fl && (64'(ea) + 64'(sz) > 64'd2048);
            e_addr = ea;
            e_off = ea + 32'd4;
            e_data = sd;
            e_valid = v && !fl;
            e_mc = (v && !fl && !flt) ? m : 25'd0;
            e_pulse = flt;
            if (flt && (!e_sticky || clr)) e_faddr = ea;
            e_sticky = flt || (e_sticky && !clr);
            if (clr) e_cnt = flt ? 1 : 0;
            else if (flt && e_cnt < 255) e_cnt++;
        end
        #1 check_all(tag);
    endtask

    initial begin
        model_reset();
        #12 check_all("reset");
        rst_n = 1;
        step("word_load", 1, 1, 0, 1, 0, 32'h100, 32'hFFFF_FFFC, 4);
        chk("tp_addr", addr, 32'h0FC);
        chk("tp_offset", offset_addr, 32'h100);
        chk("tp_valid", 32'(valid_s2), 32'd1);
        step("half_7fe", 1, 1, 0, 1, 0, 32'h7F0, 32'hE, 2);
        chk("half_7fe_nofault", 32'(fault_pulse), 32'd0);
        step("word_7fd", 1, 1, 0, 1, 0, 32'h7F0, 32'hD, 4);
        chk("word_7fd_mc", 32'(microcode_s2), 32'(MC_NOP));
        chk("word_7fd_pulse", 32'(fault_pulse), 32'd1);
        chk("word_7fd_faddr", fault_addr, 32'h7FD);
        step("clear", 1, 1, 0, 0, 1, 32'h0, 32'h0, 1);
        chk("clear_sticky", 32'(fault_sticky), 32'd0);
        step("byte_800", 1, 1, 0, 1, 0, 32'h800, 32'h0, 1);
        step("idle", 1, 0, 0, 0, 0, 32'h10, 32'h0, 1);
        step("byte_900", 1, 1, 0, 1, 0, 32'h900, 32'h0, 1);
        chk("first_fault_kept", fault_addr, 32'h800);
        step("alu_900", 1, 1, 0, 0, 0, 32'h900, 32'h0, 4);
        chk("alu_nofault", 32'(fault_pulse), 32'd0);
        for (int k = 0; k < 3; k++) step("stall", 0, 1, 0, 1, 1, 32'($urandom), 32'($urandom), 4);
        chk("stall_addr", addr, 32'h900);
        step("clear2", 1, 0, 0, 0, 1, 32'h0, 32'h0, 1);
        step("flush_fault", 1, 1, 1, 1, 0, 32'h800, 32'h0, 4);
        chk("flush_valid", 32'(valid_s2), 32'd0);
        chk("flush_sticky", 32'(fault_sticky), 32'd0);
        step("fault_a", 1, 1, 0, 1, 0, 32'h2000, 32'h0, 1);
        step("clr_fault_1000", 1, 1, 0, 1, 1, 32'h1000, 32'h0, 2);
        chk("clr_fault_sticky", 32'(fault_sticky), 32'd1);
        chk("clr_fault_faddr", fault_addr, 32'h1000);
`ifdef AGU_FAULT_COUNT_EN
        for (int k = 0; k < 300; k++) step("sat", 1, 1, 0, 1, 0, 32'h1000, 32'h0, 4);
        chk("count_sat", 32'(fault_count), 32'd255);
        step("count_clr", 1, 1, 0, 1, 1, 32'h1000, 32'h0, 4);
        chk("count_clr_fault", 32'(fault_count), 32'd1);
`endif
        for (int k = 0; k < 400; k++) begin
            logic [31:0] b;
            b = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(1990, 2100));
            step("rand", $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, b,
                 32'($urandom_range(0, 15)) - 32'd8, (1 << $urandom_range(0, 2)));
        end
        #2 rst_n = 0;
        #1 model_reset();
        check_all("async_reset");
        @(negedge clk) rst_n = 1;
        #1 check_all("post_reset");
        step("after_reset", 1, 1, 0, 1, 0, 32'h7FC, 32'h0, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_agu_stage.md
Name: mem_agu_stage

Overview:
- Pipeline stage directly upstream of the data-memory block. Registers the stage-1 to stage-2 boundary.
- Computes the effective address `addr = base + imm` and the next-word address `offset_addr = addr + 4`. Registers the store data and the stage-2 microcode.
- Detects memory accesses that fall outside the 2 KiB data aperture, or whose misaligned span wraps past the top word. Such an access is killed (converted to NOP) before it reaches the memory, and the fault is recorded in sticky status.

Parameters:
- MEM_ADDR_BITS, 11, byte-address width of the data aperture (2 KiB).
- MC_WIDTH, 25, microcode word width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_enable  in  1  global stall; registers update only when high
- valid_in  in  1  stage-1 holds a real instruction
- flush  in  1  squash the op entering stage 2
- base  in  32  rs1 value
- imm  in  32  sign-extended offset
- store_data  in  32  rs2 value
- microcode_s1  in  MC_WIDTH  microcode to advance to stage 2
- mem_access_s1  in  1  op is a load or store
- fault_clear  in  1  clears sticky fault status
- addr  out  32  registered effective address
- offset_addr  out  32  registered addr + 4
- data_in  out  32  registered store data
- microcode_s2  out  MC_WIDTH  registered microcode, or MC_NOP if killed
- valid_s2  out  1  stage-2 op valid
- fault_pulse  out  1  high for the one cycle the faulting op occupies stage 2
- fault_sticky  out  1  set on any fault; held until cleared
- fault_addr  out  32  effective address of the first fault since the last clear

Behaviour:
- Reset (async, rst_n low):
  - addr, offset_addr, data_in, fault_addr = 0.
  - microcode_s2 = MC_NOP.
  - valid_s2, fault_pulse, fault_sticky = 0.
- Latency: 1 cycle. Outputs change only on a rising clk edge with clk_enable = 1. With clk_enable = 0, every register, including the status registers, holds.
- Address arithmetic: `ea = base + imm` mod 2^32, wrap silently. `offset_addr = ea + 4` mod 2^32.
- Access size is decoded from microcode_s1 through a microcode_s2_decoder instance:
  - size 4 if enable_upper_half
  - else size 2 if enable_byte_1
  - else size 1.
- Fault condition (evaluated only when valid_in & mem_access_s1 & ~flush):
  - ea[31:MEM_ADDR_BITS] != 0, or
  - ea[MEM_ADDR_BITS-1:2] is all ones and ea[1:0] + size > 4 (the span would wrap to word 0).
  - A halfword at 0x7FE does not fault; a word at 0x7FD does.
- Next state on an enabled edge:
  - flush = 1: valid_s2 = 0, microcode_s2 = MC_NOP, fault_pulse = 0. addr and data fields still load; they are don't-care.
  - fault: valid_s2 = 1, microcode_s2 = MC_NOP, fault_pulse = 1.
  - otherwise: valid_s2 = valid_in. microcode_s2 = microcode_s1 if valid_in, else MC_NOP. fault_pulse = 0.
- Sticky status:
  - A fault sets fault_sticky. fault_addr is captured only if fault_sticky was 0.
  - fault_clear alone: fault_sticky = 0, fault_addr holds.
  - fault_clear together with a new fault: fault_sticky = 1 and fault_addr = the new ea; the new fault wins.
- A non-memory op never faults, whatever its address.

Optional Feature:
- Macro: AGU_FAULT_COUNT_EN.
- With AGU_FAULT_COUNT_EN defined:
  - Adds output fault_count[7:0], reset to 0.
  - Increments on each enabled edge that raises fault_pulse.
  - Saturates at 255.
  - Zeroed by fault_clear; clear takes priority, so a clear concurrent with a fault yields 1.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_pkg:
  - MC_NOP (25'h0), MEM_ADDR_BITS default, MEM_TOP_WORD.
  - typedef access_size_t: enum SZ_BYTE, SZ_HALF, SZ_WORD.
- One sub-module, mem_span_check (combinational): ea, size, enables → fault.
- Reuse the existing microcode_s2_decoder for size decode.

Test Plan:
- base=0x100, imm=0xFFFFFFFC, word load → next cycle addr=0x0FC, offset_addr=0x100, microcode passed through, valid_s2=1, no fault.
- Halfword store at ea 0x7FE (display) → microcode_s2 unchanged, no fault. Word store at 0x7FD → microcode_s2=MC_NOP, fault_pulse=1, fault_addr=0x7FD.
- Byte load at ea 0x800 → fault. A second fault at 0x900 two cycles later leaves fault_addr=0x800. An ALU op with ea 0x900 → no fault.
- Hold clk_enable=0 for 3 cycles mid-stream → all outputs frozen. Assert flush with a faulting op → valid_s2=0, no fault recorded.
- fault_clear on the same edge as a new fault at 0x1000 → fault_sticky=1, fault_addr=0x1000. With AGU_FAULT_COUNT_EN: 300 faults → count=255, and clear plus fault → 1.
- Assert rst_n low asynchronously mid-stream → all outputs immediately take their reset values without a clock edge.
